// File: rtl/pci_arbiter_rr.sv
// pci_arbiter_rr: round-robin PCI GNT# arbiter with two-level priority, grant withdrawal and grant timeout.
// Define PCI_ARB_PARK_EN to park the bus on master PARK when nobody requests.
module pci_arbiter_rr #(
  parameter int width = 4,
  parameter logic [width-1:0] HIPRI = '0,
  parameter int TIMEOUT = 16,
  parameter int PARK = 0,
  localparam int iw = (width > 1) ? $clog2(width) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FRAME,
  input  logic             IRDY,
  input  logic [width-1:0] REQ,
  output logic [width-1:0] GNT,
  output logic [iw-1:0]    OWNER,
  output logic             TO_ERR
);
  if (width < 2) begin : g_width_chk
    $error("pci_arbiter_rr: width must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, OFFER_HOLD, OFFER} state_t;
  localparam logic [width-1:0] all1 = '1;
`ifdef PCI_ARB_PARK_EN
  localparam logic [width-1:0] park_gnt = ~(width'(1) << PARK);
`endif
  state_t state, state_n;
  logic [iw-1:0] last, last_n, owner_n, win;
  logic [7:0] cnt, cnt_n;
  logic [width-1:0] gnt_n, req, pool;
  logic to_err_n, bus_idle, found;
  assign req = ~REQ;
  assign bus_idle = FRAME & IRDY;
  assign pool = |(req & HIPRI) ? (req & HIPRI) : req;
  // Scan starts just after the last grantee, so it is reached only after everyone else.
  always_comb begin
    win = last;
    found = 1'b0;
    for (int i = 1; i <= width; i++) begin
      if (!found && pool[(int'(last) + i) % width]) begin
        win = iw'((int'(last) + i) % width);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    last_n = last;
    cnt_n = cnt;
    gnt_n = GNT;
    owner_n = OWNER;
    to_err_n = 1'b0;
    unique case (state)
      IDLE:
        if (|req) begin
          gnt_n = ~(width'(1) << win);
          last_n = win;
          cnt_n = '0;
          state_n = bus_idle ? OFFER : OFFER_HOLD;
        end
`ifdef PCI_ARB_PARK_EN
        else if (GNT == park_gnt && !FRAME) begin
          owner_n = iw'(PARK);
          gnt_n = all1;
        end else gnt_n = bus_idle ? park_gnt : all1;
`else
        else gnt_n = all1;
`endif
      OFFER_HOLD:
        if (REQ[last]) begin
          gnt_n = all1;
          state_n = IDLE;
        end else if (bus_idle) begin
          state_n = OFFER;
          cnt_n = '0;
        end
      OFFER:
        if (!FRAME) begin
          gnt_n = all1;
          owner_n = last;
          state_n = IDLE;
        end else if (REQ[last]) begin
          gnt_n = all1;
          state_n = IDLE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          gnt_n = all1;
          to_err_n = 1'b1;
          state_n = IDLE;
        end else cnt_n = (cnt == 8'hff) ? cnt : cnt + 8'd1;
      default: begin
        gnt_n = all1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last <= iw'(width - 1);
      cnt <= '0;
      GNT <= all1;
      OWNER <= '0;
      TO_ERR <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      cnt <= cnt_n;
      GNT <= gnt_n;
      OWNER <= owner_n;
      TO_ERR <= to_err_n;
    end
  end
endmodule

// File: tb/tb_pci_arbiter_rr.sv
// tb_pci_arbiter_rr: directed and random checks of pci_arbiter_rr against a behavioural model.
module tb_pci_arbiter_rr;
  localparam int TO = 4;
  logic CLK = 1'b0;
  logic RESET, FRAME, IRDY;
  logic [3:0] REQ;
  logic [3:0] gnt0, gnt1;
  logic [1:0] own0, own1;
  logic toe0, toe1;
  int n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  pci_arbiter_rr #(.width(4), .HIPRI(4'b0000), .TIMEOUT(TO), .PARK(0)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME(FRAME), .IRDY(IRDY), .REQ(REQ),
    .GNT(gnt0), .OWNER(own0), .TO_ERR(toe0));
  pci_arbiter_rr #(.width(4), .HIPRI(4'b1000), .TIMEOUT(TO), .PARK(0)) dut_h (
    .CLK(CLK), .RESET(RESET), .FRAME(FRAME), .IRDY(IRDY), .REQ(REQ),
    .GNT(gnt1), .OWNER(own1), .TO_ERR(toe1));
  // model: mode 0 = no grant, 1 = granted but bus busy, 2 = offered on idle bus
  int m_mode[2], m_last[2], m_wait[2], m_own[2];
  logic [3:0] m_gnt[2];
  logic m_toe[2];
  logic [3:0] hp[2] = '{4'b0000, 4'b1000};
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  // choose the requester at the smallest rotational distance past last
  function automatic int pick(int last, logic [3:0] r, logic [3:0] h);
    logic [3:0] m;
    int best, bd, d;
    m = ((r & h) != 0) ? (r & h) : r;
    best = -1;
    bd = 99;
    for (int j = 0; j < 4; j++) begin
      d = (j - last - 1 + 8) % 4;
      if (m[j] && d < bd) begin
        bd = d;
        best = j;
      end
    end
    return best;
  endfunction
  function automatic void mstep(int k);
    logic [3:0] r;
    int w;
    r = ~REQ;
    m_toe[k] = 1'b0;
    if (m_mode[k] == 0) begin
      m_gnt[k] = 4'b1111;
      if (r != 0) begin
        w = pick(m_last[k], r, hp[k]);
        m_gnt[k][w] = 1'b0;
        m_last[k] = w;
        m_wait[k] = 0;
        m_mode[k] = (FRAME && IRDY) ? 2 : 1;
      end
    end else if (m_mode[k] == 1) begin
      if (REQ[m_last[k]]) begin
        m_gnt[k] = 4'b1111;
        m_mode[k] = 0;
      end else if (FRAME && IRDY) begin
        m_mode[k] = 2;
        m_wait[k] = 0;
      end
    end else begin
      if (!FRAME) begin
        m_own[k] = m_last[k];
        m_gnt[k] = 4'b1111;
        m_mode[k] = 0;
      end else if (REQ[m_last[k]]) begin
        m_gnt[k] = 4'b1111;
        m_mode[k] = 0;
      end else if (m_wait[k] + 1 == TO) begin
        m_gnt[k] = 4'b1111;
        m_toe[k] = 1'b1;
        m_mode[k] = 0;
      end else m_wait[k]++;
    end
  endfunction
  always @(posedge CLK or posedge RESET) begin
    for (int k = 0; k < 2; k++) begin
      if (RESET) begin
        m_mode[k] = 0;
        m_last[k] = 3;
        m_wait[k] = 0;
        m_own[k] = 0;
        m_gnt[k] = 4'b1111;
        m_toe[k] = 1'b0;
      end else mstep(k);
    end
  end
  always @(negedge CLK) begin
    chk("gnt0", gnt0, m_gnt[0]);
    chk("own0", own0, m_own[0]);
    chk("toe0", toe0, m_toe[0]);
    chk("gnt1", gnt1, m_gnt[1]);
    chk("own1", own1, m_own[1]);
    chk("toe1", toe1, m_toe[1]);
  end
  task automatic cyc(input logic [3:0] r, input logic f, input logic i);
    REQ = r;
    FRAME = f;
    IRDY = i;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic do_reset();
    REQ = 4'hf;
    FRAME = 1'b1;
    IRDY = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask
  initial begin
    logic [3:0] e;
    RESET = 1'b1;
    REQ = 4'hf;
    FRAME = 1'b1;
    IRDY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", gnt0, 4'b1111);
    chk("rst_own", own0, 0);
    chk("rst_toe", toe0, 0);
    RESET = 1'b0;
    cyc(4'b1110, 1, 1);
    chk("t1_gnt", gnt0, 4'b1110);
    cyc(4'b1110, 0, 1);
    chk("t1_rel", gnt0, 4'b1111);
    chk("t1_own", own0, 0);
    do_reset();
    for (int n = 0; n < 5; n++) begin
      cyc(4'b0000, 1, 1);
      e = 4'b1111;
      e[n % 4] = 1'b0;
      chk("t2_gnt", gnt0, e);
      cyc(4'b0000, 0, 1);
      chk("t2_own", own0, n % 4);
    end
    do_reset();
    cyc(4'b1110, 1, 1);
    cyc(4'b1110, 0, 1);
    cyc(4'b0110, 1, 1);
    chk("t3_hi", gnt1, 4'b0111);
    cyc(4'b0110, 0, 1);
    cyc(4'b1110, 1, 1);
    chk("t3_lo", gnt1, 4'b1110);
    cyc(4'b1110, 0, 1);
    do_reset();
    cyc(4'b1101, 1, 1);
    chk("t4_gnt1", gnt0, 4'b1101);
    repeat (3) cyc(4'b1100, 1, 1);
    chk("t4_hold", gnt0, 4'b1101);
    chk("t4_notoe", toe0, 0);
    cyc(4'b1100, 1, 1);
    chk("t4_rev", gnt0, 4'b1111);
    chk("t4_toe", toe0, 1);
    cyc(4'b1100, 1, 1);
    chk("t4_toe_1clk", toe0, 0);
    chk("t4_next", gnt0, 4'b1110);
    cyc(4'b1100, 0, 1);
    cyc(4'b1101, 1, 1);
    chk("t4b_gnt", gnt0, 4'b1101);
    repeat (3) cyc(4'b1101, 1, 1);
    cyc(4'b1101, 0, 1);
    chk("t4b_own", own0, 1);
    chk("t4b_toe", toe0, 0);
    chk("t4b_gnt_rel", gnt0, 4'b1111);
    cyc(4'b1011, 0, 0);
    chk("t5_gnt", gnt0, 4'b1011);
    for (int n = 0; n < 10; n++) begin
      cyc(4'b1011, 0, 0);
      chk("t5_hold", gnt0, 4'b1011);
      chk("t5_toe", toe0, 0);
    end
    cyc(4'b1111, 0, 0);
    chk("t5_wd", gnt0, 4'b1111);
    cyc(4'b1110, 1, 1);
    cyc(4'b1110, 1, 1);
    chk("t6_pre", gnt0, 4'b1110);
    #2 RESET = 1'b1;
    #1;
    chk("t6_gnt", gnt0, 4'b1111);
    chk("t6_toe", toe0, 0);
    #1 RESET = 1'b0;
    @(negedge CLK);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) REQ = 4'($urandom);
      FRAME = $urandom_range(2) != 0;
      IRDY = $urandom_range(3) != 0;
      @(posedge CLK);
      @(negedge CLK);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
